// File: rtl/io_arbiter.sv
// rtl/io_arbiter.sv - round-robin arbiter sharing one memory-mapped IO bus between several masters
// One transaction in flight; every output comes straight from a register.
module io_arbiter #(
    parameter int NUM_REQUESTERS = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_REQUESTERS-1:0]            req_valid,
    input  logic [NUM_REQUESTERS-1:0]            req_write,
    input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_write_data,
    output logic [NUM_REQUESTERS-1:0]            req_ready,
    output logic [NUM_REQUESTERS-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]                resp_data,
    output logic                                 io_write_en,
    output logic                                 io_read_en,
    output logic [ADDR_WIDTH-1:0]                io_address,
    output logic [DATA_WIDTH-1:0]                io_write_data,
    input  logic [DATA_WIDTH-1:0]                io_read_data
);

    localparam int GRANT_W = $clog2(NUM_REQUESTERS);
    localparam logic [GRANT_W-1:0] LAST_IDX = GRANT_W'(NUM_REQUESTERS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;

    state_t                      r_state, w_state_nxt;
    logic [GRANT_W-1:0]          r_grant, w_grant_nxt;
    logic [GRANT_W-1:0]          r_last_grant, w_last_grant_nxt;
    logic                        r_write, w_write_nxt;
    logic [NUM_REQUESTERS-1:0]   r_req_ready, w_req_ready_nxt;
    logic [NUM_REQUESTERS-1:0]   r_resp_valid, w_resp_valid_nxt;
    logic [DATA_WIDTH-1:0]       r_resp_data, w_resp_data_nxt;
    logic                        r_io_write_en, w_io_write_en_nxt;
    logic                        r_io_read_en, w_io_read_en_nxt;
    logic [ADDR_WIDTH-1:0]       r_io_address, w_io_address_nxt;
    logic [DATA_WIDTH-1:0]       r_io_write_data, w_io_write_data_nxt;

    logic                        w_found;
    logic [GRANT_W-1:0]          w_winner;
    logic                        w_sel_write;
    logic [ADDR_WIDTH-1:0]       w_sel_address;
    logic [DATA_WIDTH-1:0]       w_sel_write_data;

    function automatic logic [NUM_REQUESTERS-1:0] onehot(input logic [GRANT_W-1:0] idx);
        logic [NUM_REQUESTERS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            v[i] = (idx == GRANT_W'(i));
        end
        return v;
    endfunction

    // Round-robin: first look above the last grant, then wrap to the low indices.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!w_found && req_valid[i] && (GRANT_W'(i) > r_last_grant)) begin
                w_found  = 1'b1;
                w_winner = GRANT_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!w_found && req_valid[i] && (GRANT_W'(i) <= r_last_grant)) begin
                w_found  = 1'b1;
                w_winner = GRANT_W'(i);
            end
        end
    end

    always_comb begin
        w_sel_write      = 1'b0;
        w_sel_address    = '0;
        w_sel_write_data = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (w_winner == GRANT_W'(i)) begin
                w_sel_write      = req_write[i];
                w_sel_address    = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_write_data = req_write_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and next-output values; strobes and pulses default low each cycle.
    always_comb begin
        w_state_nxt         = r_state;
        w_grant_nxt         = r_grant;
        w_last_grant_nxt    = r_last_grant;
        w_write_nxt         = r_write;
        w_req_ready_nxt     = '0;
        w_resp_valid_nxt    = '0;
        w_resp_data_nxt     = '0;
        w_io_write_en_nxt   = 1'b0;
        w_io_read_en_nxt    = 1'b0;
        w_io_address_nxt    = r_io_address;
        w_io_write_data_nxt = r_io_write_data;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt         = ISSUE;
                    w_grant_nxt         = w_winner;
                    w_write_nxt         = w_sel_write;
                    w_req_ready_nxt     = onehot(w_winner);
                    w_io_write_en_nxt   = w_sel_write;
                    w_io_read_en_nxt    = !w_sel_write;
                    w_io_address_nxt    = w_sel_address;
                    w_io_write_data_nxt = w_sel_write_data;
                end
            end
            ISSUE: begin
                w_last_grant_nxt = r_grant;
                if (r_write) begin
                    w_state_nxt      = RESPOND;
                    w_resp_valid_nxt = onehot(r_grant);
                end else begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                w_state_nxt      = RESPOND;
                w_resp_valid_nxt = onehot(r_grant);
                w_resp_data_nxt  = io_read_data;
            end
            RESPOND: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_grant         <= '0;
            r_last_grant    <= LAST_IDX;
            r_write         <= 1'b0;
            r_req_ready     <= '0;
            r_resp_valid    <= '0;
            r_resp_data     <= '0;
            r_io_write_en   <= 1'b0;
            r_io_read_en    <= 1'b0;
            r_io_address    <= '0;
            r_io_write_data <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_grant         <= w_grant_nxt;
            r_last_grant    <= w_last_grant_nxt;
            r_write         <= w_write_nxt;
            r_req_ready     <= w_req_ready_nxt;
            r_resp_valid    <= w_resp_valid_nxt;
            r_resp_data     <= w_resp_data_nxt;
            r_io_write_en   <= w_io_write_en_nxt;
            r_io_read_en    <= w_io_read_en_nxt;
            r_io_address    <= w_io_address_nxt;
            r_io_write_data <= w_io_write_data_nxt;
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_data     = r_resp_data;
    assign io_write_en   = r_io_write_en;
    assign io_read_en    = r_io_read_en;
    assign io_address    = r_io_address;
    assign io_write_data = r_io_write_data;

endmodule

// File: tb/tb_io_arbiter.sv
// tb/tb_io_arbiter.sv - scoreboard bench for io_arbiter with a registered-read peripheral model
module tb_io_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [N-1:0] ONE = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0]    req_valid, req_write, req_ready, resp_valid;
    logic [N*AW-1:0] req_address;
    logic [N*DW-1:0] req_write_data;
    logic [DW-1:0]   resp_data, io_write_data, io_read_data;
    logic            io_write_en, io_read_en;
    logic [AW-1:0]   io_address;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct { int m; logic [DW-1:0] d; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    io_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_address(req_address), .req_write_data(req_write_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .io_write_en(io_write_en), .io_read_en(io_read_en),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(io_read_data)
    );

    function automatic logic [DW-1:0] periph(input logic [AW-1:0] a);
        return (a == 32'h2c) ? 32'hA5 : (a * 3 + 32'h1111);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        io_read_data <= io_read_en ? periph(io_address) : 32'hDEADBEEF;
    end

    // Response scoreboard: every resp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && resp_valid != '0) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid=%b data=%h, want none", resp_valid, resp_data);
            end else begin
                mon_e = sb.pop_front();
                if (resp_valid !== (ONE << mon_e.m) || resp_data !== mon_e.d) begin
                    n_fail++;
                    $display("FAIL resp_match: got valid=%b data=%h, want valid=%b data=%h",
                             resp_valid, resp_data, ONE << mon_e.m, mon_e.d);
                end
            end
        end
    end

    task automatic set_req(input int m, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [N-1:0] mask;
        mask = ONE << m;
        req_valid = req_valid | mask;
        req_write = wr ? (req_write | mask) : (req_write & ~mask);
        if (m == 0) begin
            req_address[AW-1:0]    = a;
            req_write_data[DW-1:0] = d;
        end else begin
            req_address[2*AW-1:AW]    = a;
            req_write_data[2*DW-1:DW] = d;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({req_ready, resp_valid} !== '0) begin n_fail++; $display("FAIL reset_pulses: got %b, want 0", {req_ready, resp_valid}); end
        n_checks++; if (resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data: got %h, want 0", resp_data); end
        n_checks++; if ({io_write_en, io_read_en} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b, want 00", {io_write_en, io_read_en}); end
        n_checks++; if (io_address !== '0 || io_write_data !== '0) begin n_fail++; $display("FAIL reset_bus: got addr=%h wdata=%h, want 0", io_address, io_write_data); end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({io_write_en, io_read_en, req_ready} !== '0) begin n_fail++; $display("FAIL idle_after_reset: got %b, want 0", {io_write_en, io_read_en, req_ready}); end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        set_req(0, 1'b1, 32'h00, 32'h15);
        sb.push_back('{m: 0, d: 32'h0});
        @(negedge clk);
        n_checks++; if ({io_write_en, io_read_en} !== 2'b10) begin n_fail++; $display("FAIL wr_strobes: got %b, want 10", {io_write_en, io_read_en}); end
        n_checks++; if (io_address !== 32'h00 || io_write_data !== 32'h15) begin n_fail++; $display("FAIL wr_bus: got addr=%h wdata=%h, want 0/15", io_address, io_write_data); end
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL wr_ready: got %b, want 01", req_ready); end
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (resp_valid !== 2'b01 || resp_data !== '0) begin n_fail++; $display("FAIL wr_latency: got valid=%b data=%h, want 01/0", resp_valid, resp_data); end
        @(negedge clk);
    endtask

    task automatic test_single_read();
        @(negedge clk);
        set_req(1, 1'b0, 32'h2c, 32'h0);
        sb.push_back('{m: 1, d: 32'hA5});
        @(negedge clk);
        n_checks++; if ({io_write_en, io_read_en} !== 2'b01 || io_address !== 32'h2c) begin n_fail++; $display("FAIL rd_issue: got strobes=%b addr=%h, want 01/2c", {io_write_en, io_read_en}, io_address); end
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rd_ready: got %b, want 10", req_ready); end
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (io_read_en !== 1'b0 || resp_valid !== '0) begin n_fail++; $display("FAIL rd_capture: got ren=%b valid=%b, want 0/00", io_read_en, resp_valid); end
        @(negedge clk);
        n_checks++; if (resp_valid !== 2'b10 || resp_data !== 32'hA5) begin n_fail++; $display("FAIL rd_latency: got valid=%b data=%h, want 10/a5", resp_valid, resp_data); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int k;
        int last_cyc;
        logic [N-1:0] want;
        k = 0;
        last_cyc = 0;
        @(negedge clk);
        set_req(0, 1'b0, 32'h100, 32'h0);
        set_req(1, 1'b0, 32'h204, 32'h0);
        for (int j = 0; j < 2; j++) begin
            sb.push_back('{m: 0, d: periph(32'h100)});
            sb.push_back('{m: 1, d: periph(32'h204)});
        end
        for (int t = 0; t < 40 && k < 4; t++) begin
            @(negedge clk);
            if (io_read_en) begin
                want = (k % 2 == 0) ? 2'b01 : 2'b10;
                n_checks++; if (req_ready !== want) begin n_fail++; $display("FAIL rr_grant%0d: got %b, want %b", k, req_ready, want); end
                if (k > 0) begin
                    n_checks++; if (cyc - last_cyc != 4) begin n_fail++; $display("FAIL rr_spacing%0d: got %0d, want 4", k, cyc - last_cyc); end
                end
                last_cyc = cyc;
                k++;
                if (k == 4) req_valid = '0;
            end
        end
        req_valid = '0;
        n_checks++; if (k != 4) begin n_fail++; $display("FAIL rr_timeout: got %0d grants, want 4", k); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_stability();
        @(negedge clk);
        set_req(0, 1'b0, 32'h40, 32'h0);
        sb.push_back('{m: 0, d: periph(32'h40)});
        @(negedge clk);
        n_checks++; if (io_address !== 32'h40) begin n_fail++; $display("FAIL stab_issue: got %h, want 40", io_address); end
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (io_address !== 32'h40) begin n_fail++; $display("FAIL stab_capture: got %h, want 40", io_address); end
        set_req(0, 1'b0, 32'h80, 32'h0);
        sb.push_back('{m: 0, d: periph(32'h80)});
        @(negedge clk);
        n_checks++; if (io_address !== 32'h40) begin n_fail++; $display("FAIL stab_respond: got %h, want 40", io_address); end
        @(negedge clk);
        n_checks++; if (io_address !== 32'h40 || req_ready !== '0) begin n_fail++; $display("FAIL stab_idle: got addr=%h ready=%b, want 40/00", io_address, req_ready); end
        @(negedge clk);
        n_checks++; if (io_address !== 32'h80 || req_ready !== 2'b01) begin n_fail++; $display("FAIL stab_next: got addr=%h ready=%b, want 80/01", io_address, req_ready); end
        req_valid = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int g;
        g = 0;
        @(negedge clk);
        set_req(0, 1'b0, 32'h300, 32'h0);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++; if ({io_write_en, io_read_en, req_ready, resp_valid} !== '0) begin n_fail++; $display("FAIL mid_reset_ctl: got %b, want 0", {io_write_en, io_read_en, req_ready, resp_valid}); end
        n_checks++; if (io_address !== '0 || resp_data !== '0 || io_write_data !== '0) begin n_fail++; $display("FAIL mid_reset_data: got addr=%h rdata=%h wdata=%h, want 0", io_address, resp_data, io_write_data); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        set_req(1, 1'b0, 32'h20, 32'h0);
        set_req(0, 1'b0, 32'h10, 32'h0);
        sb.push_back('{m: 0, d: periph(32'h10)});
        sb.push_back('{m: 1, d: periph(32'h20)});
        for (int t = 0; t < 30 && sb.size() > 0; t++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                if (g == 0) begin
                    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL post_reset_grant: got %b, want 01", req_ready); end
                end
                g++;
                req_valid = req_valid & ~req_ready;
            end
        end
        req_valid = '0;
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL post_reset_timeout: got %0d pending, want 0", sb.size()); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_withdrawal();
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        set_req(0, 1'b1, 32'h50, 32'h77);
        sb.push_back('{m: 0, d: 32'h0});
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01 || io_write_data !== 32'h77) begin n_fail++; $display("FAIL wd_issue: got ready=%b wdata=%h, want 01/77", req_ready, io_write_data); end
        req_valid = '0;
        set_req(1, 1'b0, 32'h60, 32'h0);
        @(negedge clk);
        req_valid = '0;
        repeat (8) begin
            @(negedge clk);
            if (req_ready[1] || resp_valid[1] || io_read_en) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL withdrawal: got grant activity for master 1, want none"); end
    endtask

    task automatic test_drain();
        repeat (4) @(negedge clk);
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL drain: got %0d pending responses, want 0", sb.size()); end
    endtask

    initial begin
        req_valid      = '0;
        req_write      = '0;
        req_address    = '0;
        req_write_data = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_stability();
        test_reset_mid_read();
        test_withdrawal();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
